window_packer: RTL and testbench

- Upstream neighbour of the window alignment stage.
- Accepts a serial pixel stream over a valid/ready handshake and packs WORDS consecutive pixels into one wide write word.
- Generates the write-enable, block address and row address for each packed word, presented as one structs::struct_windowAlignment bundle for the alignment stage's waIn.
- A small state machine frames one image per start pulse and reports frame completion.

---
 rtl/pkg_windowAlignment.sv | 6 +
 rtl/structs.sv | 11 +
 rtl/window_packer.sv | 104 ++++++++++
 tb/tb_window_packer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pkg_windowAlignment.sv
// rtl/pkg_windowAlignment.sv - geometry shared by the packer and the window alignment stage
package pkg_windowAlignment;
  localparam int WORDS       = 4;
  localparam int WORD_SIZE   = 8;
  localparam int INDEX_WIDTH = 4;
endpackage

// File: rtl/structs.sv
// rtl/structs.sv - write bundle consumed by the alignment stage's waIn
package structs;
  import pkg_windowAlignment::*;

  typedef struct packed {
    logic                            we;
    logic [INDEX_WIDTH-1:0]          waddrY;
    logic [INDEX_WIDTH-1:0]          waddrBlock;
    logic [WORDS-1:0][WORD_SIZE-1:0] wdata;
  } struct_windowAlignment;
endpackage

// File: rtl/window_packer.sv
// rtl/window_packer.sv - packs WORDS serial pixels per wide word and addresses it by block/row
module window_packer
  import pkg_windowAlignment::*;
  import structs::*;
#(
  parameter int BLOCKS = 4,
  parameter int ROWS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_SIZE-1:0]  in_data,
  input  logic                  in_sof,
  output struct_windowAlignment waOut,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int LANE_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [LANE_W-1:0]      LAST_LANE  = LANE_W'(WORDS - 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_BLOCK = INDEX_WIDTH'(BLOCKS - 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_ROW   = INDEX_WIDTH'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nextState;

  logic [LANE_W-1:0]               lane, effLane;
  logic [INDEX_WIDTH-1:0]          block, row, effBlock, effRow;
  logic [WORDS-1:0][WORD_SIZE-1:0] laneData, fullWord;
  logic                            xfer, fill, lastWord;

  assign in_ready = (state == RUN);
  assign xfer     = in_valid && in_ready;

  // A start-of-frame pixel is placed as if the counters had already been cleared.
  always_comb begin
    effLane  = in_sof ? '0 : lane;
    effBlock = in_sof ? '0 : block;
    effRow   = in_sof ? '0 : row;
    fill     = xfer && (effLane == LAST_LANE);
    lastWord = fill && (effBlock == LAST_BLOCK) && (effRow == LAST_ROW);
    fullWord = laneData;
    fullWord[effLane] = in_data;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = RUN;
      RUN:     if (lastWord) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane       <= '0;
      block      <= '0;
      row        <= '0;
      laneData   <= '0;
      waOut      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      waOut.we   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= (nextState != IDLE);
      if (state == IDLE && start) begin
        lane  <= '0;
        block <= '0;
        row   <= '0;
      end
      if (xfer) begin
        laneData[effLane] <= in_data;
        if (fill) begin
          waOut.we         <= 1'b1;
          waOut.wdata      <= fullWord;
          waOut.waddrBlock <= effBlock;
          waOut.waddrY     <= effRow;
          frame_done       <= lastWord;
          lane             <= '0;
          if (effBlock == LAST_BLOCK) begin
            block <= '0;
            row   <= (effRow == LAST_ROW) ? '0 : effRow + 1'b1;
          end else begin
            block <= effBlock + 1'b1;
            row   <= effRow;
          end
        end else begin
          lane  <= effLane + 1'b1;
          block <= effBlock;
          row   <= effRow;
        end
      end
    end
  end
endmodule

// File: tb/tb_window_packer.sv
// tb/tb_window_packer.sv - directed bench for window_packer with BLOCKS=2, ROWS=2
module tb_window_packer;
  import pkg_windowAlignment::*;
  import structs::*;

  localparam int BLOCKS = 2;
  localparam int ROWS   = 2;
  localparam int DW     = WORDS * WORD_SIZE;

  logic                  clk = 1'b0;
  logic                  reset, start, in_valid, in_sof;
  logic [WORD_SIZE-1:0]  in_data;
  logic                  in_ready, busy, frame_done;
  struct_windowAlignment waOut;

  window_packer #(.BLOCKS(BLOCKS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .waOut(waOut), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            y;
    int            b;
    logic [DW-1:0] d;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0, errors = 0, cycle = 0, doneCount = 0, xferInWord = 0, fillCycle = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard: every write must match the next expected word and trail its filling transfer by one cycle.
  always @(negedge clk) begin
    if (waOut.we) begin
      if (expQ.size() == 0) check("unexpected_we", 64'(1), 64'(0));
      else begin
        exp_t e;
        e = expQ.pop_front();
        check("waddrY", 64'(waOut.waddrY), 64'(e.y));
        check("waddrBlock", 64'(waOut.waddrBlock), 64'(e.b));
        check("wdata", 64'(waOut.wdata), 64'(e.d));
        check("we_latency", 64'(cycle), 64'(fillCycle));
      end
    end
    if (frame_done) begin
      doneCount++;
      check("done_with_we", 64'(waOut.we), 64'(1));
      check("done_row", 64'(waOut.waddrY), 64'(ROWS - 1));
      check("done_block", 64'(waOut.waddrBlock), 64'(BLOCKS - 1));
    end
    if (reset) xferInWord = 0;
    else if (in_valid && in_ready) begin
      xferInWord = in_sof ? 1 : xferInWord + 1;
      if (xferInWord == WORDS) begin
        fillCycle  = cycle + 1;
        xferInWord = 0;
      end
    end
  end

  task automatic expectWord(input int y, input int b, input int base);
    exp_t e;
    e.y = y;
    e.b = b;
    for (int i = 0; i < WORDS; i++) e.d[i*WORD_SIZE +: WORD_SIZE] = WORD_SIZE'(base + i);
    expQ.push_back(e);
  endtask

  task automatic push(input int d, input bit sof, input int maxGap);
    bit ok = 1'b0;
    repeat ($urandom_range(0, maxGap)) begin @(posedge clk); #1; end
    in_data  = WORD_SIZE'(d);
    in_sof   = sof;
    in_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("push_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic pushRange(input int first, input int n, input int maxGap);
    for (int i = 0; i < n; i++) push(first + i, 1'b0, maxGap);
  endtask

  task automatic expectFrame(input int base);
    for (int w = 0; w < BLOCKS * ROWS; w++) expectWord(w / BLOCKS, w % BLOCKS, base + w * WORDS);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 20 && expQ.size() != 0; t++) @(negedge clk);
    check(tag, 64'(expQ.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 64'(waOut.we), 64'(0));
    check("rst_waddrY", 64'(waOut.waddrY), 64'(0));
    check("rst_waddrBlock", 64'(waOut.waddrBlock), 64'(0));
    check("rst_wdata", 64'(waOut.wdata), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Gapless frame of pixels 0..15
    expectFrame(0);
    pulseStart();
    check("t1_busy", 64'(busy), 64'(1));
    check("t1_ready", 64'(in_ready), 64'(1));
    pushRange(0, 16, 0);
    check("t1_ready_after_last", 64'(in_ready), 64'(0));
    drain("t1_drain");
    check("t1_done_count", 64'(doneCount), 64'(1));
    check("t1_idle_busy", 64'(busy), 64'(0));
    check("t1_idle_ready", 64'(in_ready), 64'(0));

    // Same frame with random valid gaps
    expectFrame(0);
    pulseStart();
    pushRange(0, 16, 3);
    drain("t2_drain");
    check("t2_done_count", 64'(doneCount), 64'(2));

    // Partial word discarded by in_sof
    pulseStart();
    expectWord(0, 0, 20);
    pushRange(0, 2, 0);
    push(20, 1'b1, 0);
    pushRange(21, 3, 0);
    drain("t3_drain");

    // Reset mid-frame after 6 pixels
    expectWord(0, 0, 50);
    push(50, 1'b1, 0);
    pushRange(51, 5, 0);
    drain("t4_pre_drain");
    reset = 1'b1;
    #1;
    check("t4_rst_we", 64'(waOut.we), 64'(0));
    check("t4_rst_wdata", 64'(waOut.wdata), 64'(0));
    check("t4_rst_waddrY", 64'(waOut.waddrY), 64'(0));
    check("t4_rst_waddrBlock", 64'(waOut.waddrBlock), 64'(0));
    check("t4_rst_busy", 64'(busy), 64'(0));
    check("t4_rst_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t4_we_after_release", 64'(waOut.we), 64'(0));
    @(posedge clk); #1;
    check("t4_idle_ready", 64'(in_ready), 64'(0));
    pulseStart();
    expectWord(0, 0, 100);
    pushRange(100, 4, 0);
    drain("t4_drain");

    // start during RUN must not restart the counters
    pulseStart();
    expectWord(0, 1, 104);
    expectWord(1, 0, 108);
    expectWord(1, 1, 112);
    pushRange(104, 12, 1);
    drain("t5_drain");
    check("t5_done_count", 64'(doneCount), 64'(3));
    in_data  = WORD_SIZE'(77);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t5_idle_ready", 64'(in_ready), 64'(0));
      check("t5_idle_busy", 64'(busy), 64'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Back-to-back frames; first start coincides with a valid pixel that must not transfer
    in_data  = WORD_SIZE'(99);
    in_valid = 1'b1;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    expectFrame(200);
    pushRange(200, 16, 0);
    drain("t6a_drain");
    expectFrame(30);
    pulseStart();
    pushRange(30, 16, 0);
    drain("t6b_drain");
    check("t6_done_count", 64'(doneCount), 64'(5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
